store_buffer: RTL and testbench

- In-order FIFO of pending stores between the memory-stage store-data alignment logic and the data bus.
- Accepts already-aligned writes (word address, 4-bit byte enable, lane-positioned data) and drains them to the data bus over a valid/ready handshake.
- Flags loads that overlap a still-pending store, so the pipeline stalls them until the bytes are visible in memory.

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/store_buffer_if.sv | 51 +++++
 rtl/store_buffer.sv | 107 ++++++++++
 tb/tb_store_buffer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_pkg
// Description : Shared types for the store buffer: data word, byte-enable
//               mask and the store-buffer entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  m_wen_t;

  // One pending store: word address, lane enables, lane-positioned data.
  typedef struct packed {
    logic [29:0] addr;
    m_wen_t      en;
    word_t       wd;
  } sb_entry_t;

endpackage : store_buffer_pkg
`default_nettype wire

// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_if
// Description : Push, drain and load-query signal bundle of the store buffer.
//               The slave modport is the buffer's view; master is the
//               pipeline/bus side.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_buffer_if;
  import store_buffer_pkg::*;

  // Push side (memory stage)
  logic   push_valid;
  logic   push_ready;
  word_t  push_addr;
  m_wen_t push_en;
  word_t  push_wd;

  // Drain side (data bus)
  logic   dreq_valid;
  logic   dreq_ready;
  word_t  dreq_addr;
  m_wen_t dreq_en;
  word_t  dreq_wd;

  // Load overlap query
  logic   ld_valid;
  word_t  ld_addr;
  m_wen_t ld_en;
  logic   ld_conflict;

  modport slave (
    input  push_valid, push_addr, push_en, push_wd,
    output push_ready,
    output dreq_valid, dreq_addr, dreq_en, dreq_wd,
    input  dreq_ready,
    input  ld_valid, ld_addr, ld_en,
    output ld_conflict
  );

  modport master (
    output push_valid, push_addr, push_en, push_wd,
    input  push_ready,
    input  dreq_valid, dreq_addr, dreq_en, dreq_wd,
    output dreq_ready,
    output ld_valid, ld_addr, ld_en,
    input  ld_conflict
  );

endinterface : store_buffer_if
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : In-order FIFO of aligned pending stores drained to the data
//               bus, with a combinational load/store overlap detector.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  store_buffer_if.slave   sb,
  output logic [PTR_W:0]  count,
  output logic            empty
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q,  head_d;
  logic [PTR_W-1:0] tail_q,  tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  sb_entry_t        entries_q [DEPTH];

  logic             push_fire;
  logic             pop_fire;
  logic [DEPTH-1:0] hit;
  sb_entry_t        head_entry;

  // Byte-offset bits are meaningless for word-granular stores and loads.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{sb.push_addr[1:0], sb.ld_addr[1:0]};

  // Occupancy and handshake decode. push_ready looks only at registered
  // state so the bus-side ready never reaches the push side combinationally.
  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign sb.push_ready = resetn && (count_q < FULL_COUNT);
  assign sb.dreq_valid = !empty;
  assign push_fire     = sb.push_valid && sb.push_ready && (sb.push_en != '0);
  assign pop_fire      = sb.dreq_valid && sb.dreq_ready;

  assign head_entry    = entries_q[head_q];
  assign sb.dreq_addr  = {head_entry.addr, 2'b00};
  assign sb.dreq_en    = head_entry.en;
  assign sb.dreq_wd    = head_entry.wd;

  // Next-state for pointers, occupancy count and entry valid bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    // Push and pop never target the same slot: that needs count 0 or DEPTH,
    // where one of the two is blocked.
    if (pop_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push_fire) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (push_fire && !pop_fire) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop_fire && !push_fire) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Control state register; reset drops every pending entry at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; validity is tracked separately, so no reset.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      entries_q[tail_q] <= '{addr: sb.push_addr[31:2], en: sb.push_en, wd: sb.push_wd};
    end
  end

  // Per-entry overlap comparators; only already-stored entries participate.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign hit[gi] = valid_q[gi]
                  && (entries_q[gi].addr == sb.ld_addr[31:2])
                  && ((entries_q[gi].en & sb.ld_en) != '0);
  end

  assign sb.ld_conflict = sb.ld_valid && (|hit);

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer: directed scenarios plus
//               randomized traffic checked against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [CW-1:0] count;
  logic          empty;

  int vectors     = 0;
  int miscompares = 0;

  store_buffer_if sbif ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sbif.slave),
    .count  (count),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  // Reference model: pending stores in program order.
  sb_entry_t model_q[$];

  function automatic logic model_conflict(logic v, word_t a, m_wen_t e);
    logic r = 1'b0;
    if (v) begin
      foreach (model_q[k]) begin
        if (model_q[k].addr == a[31:2] && (model_q[k].en & e) != 4'b0) r = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbif.push_valid = 1'b0;
    sbif.push_addr  = '0;
    sbif.push_en    = '0;
    sbif.push_wd    = '0;
    sbif.dreq_ready = 1'b0;
    sbif.ld_valid   = 1'b0;
    sbif.ld_addr    = '0;
    sbif.ld_en      = '0;
  endtask

  task automatic set_push(logic v, word_t a, m_wen_t e, word_t d);
    sbif.push_valid = v;
    sbif.push_addr  = a;
    sbif.push_en    = e;
    sbif.push_wd    = d;
  endtask

  task automatic set_load(logic v, word_t a, m_wen_t e);
    sbif.ld_valid = v;
    sbif.ld_addr  = a;
    sbif.ld_en    = e;
  endtask

  task automatic test_reset();
    idle();
    set_load(1'b1, 32'h0, 4'hF);
    resetn = 1'b0;
    #2;
    vectors++; if (sbif.push_ready !== 1'b0) begin miscompares++; $display("FAIL reset_push_ready: got %b exp 0", sbif.push_ready); end
    vectors++; if (sbif.dreq_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dreq_valid: got %b exp 0", sbif.dreq_valid); end
    vectors++; if (sbif.ld_conflict !== 1'b0) begin miscompares++; $display("FAIL reset_ld_conflict: got %b exp 0", sbif.ld_conflict); end
    vectors++; if (empty !== 1'b1 || count !== '0) begin miscompares++; $display("FAIL reset_occupancy: got empty=%b count=%0d exp 1/0", empty, count); end
    step(); step();
    @(negedge clk);
    resetn = 1'b1;
    step();
    idle();
    #1;
    vectors++; if (sbif.push_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_push_ready: got %b exp 1", sbif.push_ready); end
  endtask

  task automatic test_single();
    sbif.dreq_ready = 1'b1;
    set_push(1'b1, 32'h8000_0004, 4'b0011, 32'h0000_BEEF);
    #1;
    vectors++; if (sbif.dreq_valid !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass: got %b exp 0", sbif.dreq_valid); end
    step();
    set_push(1'b0, '0, '0, '0);
    #1;
    vectors++; if (sbif.dreq_valid !== 1'b1) begin miscompares++; $display("FAIL single_dreq_valid: got %b exp 1", sbif.dreq_valid); end
    vectors++; if (sbif.dreq_addr !== 32'h8000_0004 || sbif.dreq_en !== 4'b0011 || sbif.dreq_wd !== 32'h0000_BEEF) begin
      miscompares++; $display("FAIL single_dreq_fields: got %h/%b/%h exp 80000004/0011/0000beef", sbif.dreq_addr, sbif.dreq_en, sbif.dreq_wd);
    end
    step();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL single_drained: got empty=%b exp 1", empty); end
    idle();
  endtask

  task automatic test_fill_drain();
    word_t data [4];
    sbif.dreq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data[i] = $urandom;
      set_push(1'b1, 32'h10 + 32'(4*i), 4'hF, data[i]);
      step();
      vectors++; if (sbif.dreq_valid !== 1'b1 || sbif.dreq_addr !== 32'h10 || sbif.dreq_wd !== data[0]) begin
        miscompares++; $display("FAIL fill_hold_%0d: got v=%b addr=%h wd=%h exp 1/00000010/%h", i, sbif.dreq_valid, sbif.dreq_addr, sbif.dreq_wd, data[0]);
      end
    end
    set_push(1'b0, '0, '0, '0);
    #1;
    vectors++; if (count !== CW'(4) || sbif.push_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full: got count=%0d ready=%b exp 4/0", count, sbif.push_ready); end
    sbif.dreq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (sbif.dreq_valid !== 1'b1 || sbif.dreq_addr !== 32'h10 + 32'(4*i) || sbif.dreq_wd !== data[i]) begin
        miscompares++; $display("FAIL drain_order_%0d: got v=%b addr=%h wd=%h exp 1/%h/%h", i, sbif.dreq_valid, sbif.dreq_addr, sbif.dreq_wd, 32'h10 + 32'(4*i), data[i]);
      end
      step();
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b exp 1", empty); end
    idle();
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'h200 + 32'(4*i), 4'b0101, 32'hA0 + 32'(i));
      step();
    end
    // Full and both sides requesting: only the pop happens.
    set_push(1'b1, 32'h40, 4'b1111, 32'h4040_4040);
    sbif.dreq_ready = 1'b1;
    #1;
    vectors++; if (sbif.push_ready !== 1'b0) begin miscompares++; $display("FAIL full_push_ready: got %b exp 0", sbif.push_ready); end
    step();
    sbif.dreq_ready = 1'b0;
    #1;
    vectors++; if (count !== CW'(3) || sbif.push_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop_only: got count=%0d ready=%b exp 3/1", count, sbif.push_ready); end
    step();
    set_push(1'b0, '0, '0, '0);
    #1;
    vectors++; if (count !== CW'(4)) begin miscompares++; $display("FAIL full_refill: got count=%0d exp 4", count); end
    sbif.dreq_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      word_t ea = (i < 4) ? 32'h200 + 32'(4*i) : 32'h40;
      #1;
      vectors++; if (sbif.dreq_addr !== ea) begin miscompares++; $display("FAIL wrap_order_%0d: got %h exp %h", i, sbif.dreq_addr, ea); end
      step();
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b exp 1", empty); end
    idle();
  endtask

  task automatic test_conflict();
    // The store being pushed this cycle must not be visible to the query.
    set_push(1'b1, 32'h20, 4'b1000, 32'h1100_0000);
    set_load(1'b1, 32'h20, 4'b1000);
    #1;
    vectors++; if (sbif.ld_conflict !== 1'b0) begin miscompares++; $display("FAIL conf_same_cycle_push: got %b exp 0", sbif.ld_conflict); end
    step();
    set_push(1'b0, '0, '0, '0);
    set_load(1'b1, 32'h23, 4'b1000); #1;
    vectors++; if (sbif.ld_conflict !== 1'b1) begin miscompares++; $display("FAIL conf_hit: got %b exp 1", sbif.ld_conflict); end
    set_load(1'b1, 32'h20, 4'b0001); #1;
    vectors++; if (sbif.ld_conflict !== 1'b0) begin miscompares++; $display("FAIL conf_lane_miss: got %b exp 0", sbif.ld_conflict); end
    set_load(1'b1, 32'h24, 4'b1000); #1;
    vectors++; if (sbif.ld_conflict !== 1'b0) begin miscompares++; $display("FAIL conf_addr_miss: got %b exp 0", sbif.ld_conflict); end
    set_load(1'b0, 32'h20, 4'b1000); #1;
    vectors++; if (sbif.ld_conflict !== 1'b0) begin miscompares++; $display("FAIL conf_no_valid: got %b exp 0", sbif.ld_conflict); end
    // Entry popping this cycle still counts.
    set_load(1'b1, 32'h20, 4'b1100);
    sbif.dreq_ready = 1'b1; #1;
    vectors++; if (sbif.ld_conflict !== 1'b1) begin miscompares++; $display("FAIL conf_popping: got %b exp 1", sbif.ld_conflict); end
    step();
    vectors++; if (sbif.ld_conflict !== 1'b0) begin miscompares++; $display("FAIL conf_after_pop: got %b exp 0", sbif.ld_conflict); end
    idle();
  endtask

  task automatic test_zero_en();
    sbif.dreq_ready = 1'b1;
    set_push(1'b1, 32'h60, 4'b0000, 32'hDEAD_DEAD);
    #1;
    vectors++; if (sbif.push_ready !== 1'b1) begin miscompares++; $display("FAIL zero_en_ready: got %b exp 1", sbif.push_ready); end
    step();
    vectors++; if (count !== '0 || sbif.dreq_valid !== 1'b0) begin miscompares++; $display("FAIL zero_en_dropped: got count=%0d v=%b exp 0/0", count, sbif.dreq_valid); end
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h300 + 32'(4*i), 4'b0010, 32'(i));
      step();
    end
    set_push(1'b0, '0, '0, '0);
    #1;
    vectors++; if (count !== CW'(3)) begin miscompares++; $display("FAIL areset_pre_count: got %0d exp 3", count); end
    sbif.dreq_ready = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    vectors++; if (sbif.dreq_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
      miscompares++; $display("FAIL areset_immediate: got v=%b count=%0d empty=%b exp 0/0/1", sbif.dreq_valid, count, empty);
    end
    sbif.dreq_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step();
    set_push(1'b1, 32'h50, 4'b0100, 32'h0055_0000);
    step();
    set_push(1'b0, '0, '0, '0);
    #1;
    vectors++; if (sbif.dreq_valid !== 1'b1 || sbif.dreq_addr !== 32'h50 || count !== CW'(1)) begin
      miscompares++; $display("FAIL areset_recover: got v=%b addr=%h count=%0d exp 1/00000050/1", sbif.dreq_valid, sbif.dreq_addr, count);
    end
    sbif.dreq_ready = 1'b1;
    step();
    idle();
    model_q.delete();
  endtask

  task automatic test_random();
    logic   pv, dr, lv, exp_pr, exp_dv, exp_cf;
    word_t  pa, pd, la;
    m_wen_t pe, le;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pv = 1'($urandom_range(0, 1));
      pa = 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      pe = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom);
      pd = $urandom;
      dr = ($urandom_range(0, 2) != 0);
      lv = 1'($urandom_range(0, 1));
      la = 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      le = 4'($urandom);
      set_push(pv, pa, pe, pd);
      sbif.dreq_ready = dr;
      set_load(lv, la, le);
      #1;
      exp_pr = (model_q.size() < DEPTH);
      exp_dv = (model_q.size() != 0);
      exp_cf = model_conflict(lv, la, le);
      vectors++; if (sbif.push_ready !== exp_pr) begin miscompares++; $display("FAIL rnd_push_ready c%0d: got %b exp %b", cyc, sbif.push_ready, exp_pr); end
      vectors++; if (sbif.dreq_valid !== exp_dv) begin miscompares++; $display("FAIL rnd_dreq_valid c%0d: got %b exp %b", cyc, sbif.dreq_valid, exp_dv); end
      if (exp_dv) begin
        vectors++; if (sbif.dreq_addr !== {model_q[0].addr, 2'b00} || sbif.dreq_en !== model_q[0].en || sbif.dreq_wd !== model_q[0].wd) begin
          miscompares++; $display("FAIL rnd_head c%0d: got %h/%b/%h exp %h/%b/%h", cyc, sbif.dreq_addr, sbif.dreq_en, sbif.dreq_wd, {model_q[0].addr, 2'b00}, model_q[0].en, model_q[0].wd);
        end
      end
      vectors++; if (sbif.ld_conflict !== exp_cf) begin miscompares++; $display("FAIL rnd_conflict c%0d: got %b exp %b", cyc, sbif.ld_conflict, exp_cf); end
      if (exp_dv && dr) void'(model_q.pop_front());
      if (pv && exp_pr && pe != 4'b0) model_q.push_back('{addr: pa[31:2], en: pe, wd: pd});
      step();
      vectors++; if (count !== CW'(model_q.size()) || empty !== (model_q.size() == 0)) begin
        miscompares++; $display("FAIL rnd_count c%0d: got count=%0d empty=%b exp %0d", cyc, count, empty, model_q.size());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pushpop();
    test_conflict();
    test_zero_en();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule : tb_store_buffer
`default_nettype wire
